// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the modulo-N counter family
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Terminal value for a given modulus and direction: top of range when
    // counting up, zero when counting down.
    function automatic longint term_value(input longint modulus, input logic dir);
        return (dir == DIR_UP) ? (modulus - longint'(1)) : longint'(0);
    endfunction

    // Legal configuration: 2..32 bits, modulus fits the width, reset value in range.
    function automatic bit params_legal(input int width, input longint modulus,
                                        input longint reset_val);
        return (width >= 2) && (width <= 32) &&
               (modulus >= longint'(2)) && (modulus <= (longint'(1) << width)) &&
               (reset_val >= longint'(0)) && (reset_val < modulus);
    endfunction

endpackage

// File: rtl/mod_step.sv
// rtl/mod_step.sv - combinational next-value and wrap detection for one count step
module mod_step
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap
);

    // The increment is done one bit wider so MODULUS = 2**WIDTH compares cleanly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - longint'(1));

    logic [WIDTH:0] inc;

    // Step one position in the requested direction, wrapping at the range ends.
    always_comb begin
        inc    = {1'b0, q} + (WIDTH + 1)'(1);
        next_q = q;
        wrap   = 1'b0;
        if (up == DIR_UP) begin
            if (inc >= MOD_EXT) begin
                next_q = '0;
                wrap   = 1'b1;
            end else begin
                next_q = inc[WIDTH-1:0];
            end
        end else begin
            if (q == '0) begin
                next_q = MAX_Q;
                wrap   = 1'b1;
            end else begin
                next_q = q - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - loadable modulo-N up/down counter with one-shot, overflow and compare
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH     = 8,
    parameter longint MODULUS   = 256,
    parameter longint RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spe_n,
    input  logic [WIDTH-1:0] p,
    input  logic             cep,
    input  logic             cet,
    input  logic             up,
    input  logic             oneshot,
    input  logic             clr_ovf,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             done,
    output logic             match
);

    if (!params_legal(WIDTH, MODULUS, RESET_VAL)) begin : g_bad_params
        $error("mod_updown_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - longint'(1));
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] term;
    logic             at_term;
    logic             step_en;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_q;
    logic             step_wrap;

    mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q      (q),
        .up     (up),
        .next_q (step_q),
        .wrap   (step_wrap)
    );

    // Terminal detection, cascade output, count qualification and load clamping.
    always_comb begin
        term     = WIDTH'(term_value(MODULUS, up));
        at_term  = (q == term);
        tc       = cet & at_term;
        step_en  = cep & cet & ~done;
        load_val = ({1'b0, p} >= MOD_EXT) ? MAX_Q : p;
    end

    // Count register and one-shot completion: reset > load > step > hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= RST_Q;
            done <= 1'b0;
        end else if (!spe_n) begin
            q    <= load_val;
            done <= 1'b0;
        end else if (step_en) begin
            if (oneshot && at_term) begin
                done <= 1'b1;
            end else begin
                q <= step_q;
            end
        end
    end

    // Sticky wrap flag; a wrap on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (spe_n && step_en && !(oneshot && at_term) && step_wrap) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    // Compare result lags q by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else begin
            match <= (q == cmp_val);
        end
    end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous modulo-N up/down counter. It is the general-purpose successor to the team's fixed 4-bit loadable counter and adds:
- configurable width and modulus,
- direction control and split count enables for cascading,
- a one-shot (stop-at-terminal) mode,
- a sticky overflow flag and a registered compare-match output.

It is used for decade/BCD chains, programmable dividers and event timers.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- MODULUS, 256, count range 0..MODULUS-1; legal range 2..2**WIDTH.
- RESET_VAL, 0, value of q after reset; must be < MODULUS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- spe_n  in  1  parallel load enable, active-low.
- p  in  WIDTH  parallel load data.
- cep  in  1  count enable (parallel); does not gate tc.
- cet  in  1  count enable (trickle); gates tc.
- up  in  1  direction: 1 = increment, 0 = decrement.
- oneshot  in  1  1 = stop at terminal value, 0 = free-run with wrap.
- clr_ovf  in  1  clears the ovf flag.
- cmp_val  in  WIDTH  compare value for match.
- q  out  WIDTH  count value.
- tc  out  1  terminal count, combinational.
- ovf  out  1  sticky wrap flag.
- done  out  1  one-shot completed, sticky.
- match  out  1  registered compare result.

## Operation
- Terminal value: term = MODULUS-1 when up=1, and 0 when up=0.
- Step: counting is enabled when cep & cet & !done.
- Priority at each edge: reset > load > step > hold.
- Reset (rst_n=0): q=RESET_VAL, ovf=0, done=0, match=0.
- Load (spe_n=0): q <= p, or MODULUS-1 if p ≥ MODULUS (clamped). Load also sets done <= 0. Load takes precedence over cep/cet.
- Free-run step (oneshot=0):
  - up: q <= q+1; MODULUS-1 wraps to 0.
  - down: q <= q-1; 0 wraps to MODULUS-1.
  - Each wrap sets ovf <= 1.
- One-shot step (oneshot=1):
  - If q ≠ term, step normally.
  - If q = term, q holds and done <= 1. ovf is not set.
- done freezes counting until load or reset. tc is still driven while done=1.
- ovf: cleared by clr_ovf=1; a wrap in the same cycle wins, so ovf stays 1.
- tc = cet & (q == term). It is independent of cep, spe_n and done. It feeds the cet input of the next stage in a cascade.
- match <= (q == cmp_val), sampled every non-reset cycle.
- Changes to up or oneshot take effect combinationally on term/tc and on the step at the next edge. There is no pipelining of the mode inputs.
- Arithmetic: the next value is computed at WIDTH+1 bits and then compared against MODULUS, so there is no overflow when MODULUS = 2**WIDTH.

## Timing
- q, ovf, done and match are registered, with latency 1 cycle from the controlling input edge.
- match is valid one cycle after q: it reflects q of the previous cycle.
- tc is combinational from q, up and cet, with zero latency.
- Cascading: stage k+1 is given cet = tc of stage k and a shared cep. The chain then rolls over in the same edge with no extra latency.
- Reset mid-operation overrides any load or step in that cycle.

## Structure
- Shared package counter_pkg:
  - DIR_UP=1'b1, DIR_DOWN=1'b0;
  - a constant function computing term from MODULUS and direction;
  - parameter-legality checks, as elaboration-time assertions.
- One combinational sub-module, mod_step. Inputs: q, up, MODULUS. Outputs: next value and wrap flag. The top module holds all registers, priority logic, one-shot control and flags.

## Test plan
All scenarios use WIDTH=4, MODULUS=10.
1. Reset: drive rst_n=0 for 1 edge with spe_n=0, p=5 -> q=0, ovf=0, done=0, match=0. Load is ignored.
2. Up wrap: up=1, cep=cet=1, start at 0, run 10 edges -> q sequence is 1..9 then 0; tc=1 only while q=9; ovf rises on the 9->0 edge. Asserting clr_ovf on that same edge -> ovf stays 1.
3. Down and clamp: load p=3, up=0 -> q steps 3, 2, 1, 0, 9; tc=1 at q=0. Then load p=12 with cep=cet=1 -> q=9, load wins.
4. One-shot: oneshot=1, up=1, load 7 -> q steps 7, 8, 9, then holds 9; done=1 on the edge after 9 is reached; ovf stays 0. Load 0 -> done=0 and counting resumes.
5. Cascade: two instances, cep shared, stage-1 cet = stage-0 tc -> count 00..99 then 00; both stages roll over on the same edge; stage-0 tc does not depend on cep.
6. Match and cet gating: cmp_val=4 -> match=1 exactly one cycle after q=4. Setting cet=0 -> q holds and tc=0.
